// File: rtl/data_mem_ctrl.sv
// Purpose : RV32I load/store unit; runs one ready/ack data-memory transaction per load/store and returns extended load data.
// Latency : request cycle + bus wait (>=1) + DONE cycle; illegal accesses finish in one cycle with fault.
// Backpress: stall freezes the PC from the request cycle until DONE; bus_ack gates completion, watchdog aborts after TIMEOUT_CYCLES.
//
// Ports:
//   clk, nRst                      - clock, async active-low reset
//   mem_read, mem_write, funct3    - request and access size/sign (held for the whole instruction)
//   addr, store_data               - effective address and rs2 value
//   bus_rdata, bus_ack             - memory read data and completion strobe
//   bus_addr/wdata/be/ren/wen      - memory request (word aligned, lane replicated)
//   load_data, stall, fault        - writeback data, PC disable, one-cycle error flag
module data_mem_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    output logic        bus_ren,
    output logic        bus_wen,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        fault
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] load_data_q, load_data_d;
    logic        fault_q, fault_d;
    logic [31:0] cnt_q, cnt_d;

    logic        req;
    logic        legal;
    logic        tmo_hit;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    assign req = mem_read | mem_write;

    // funct3[1:0]: 00 byte, 01 half, 10 word, 11 reserved; funct3[2] set on 11x is reserved too.
    always_comb begin
        legal = 1'b0;
        case (funct3)
            3'b000, 3'b100: legal = 1'b1;
            3'b001, 3'b101: legal = ~addr[0];
            3'b010:         legal = (addr[1:0] == 2'b00);
            default:        legal = 1'b0;
        endcase
    end

    // Watchdog fires on the last allowed wait cycle; ack in that same cycle still completes.
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TMO_LAST);

    assign byte_sel = bus_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign half_sel = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];

    always_comb begin
        load_ext = bus_rdata;
        case (funct3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_ext = {24'h0, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_ext = {16'h0, half_sel};
            default: load_ext = bus_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        funct3_d    = funct3_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        load_data_d = load_data_q;
        cnt_d       = cnt_q;
        fault_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d   = addr;
                    funct3_d = funct3;
                    cnt_d    = 32'd0;
                    case (funct3[1:0])
                        2'b00: begin
                            be_d    = 4'b0001 << addr[1:0];
                            wdata_d = {4{store_data[7:0]}};
                        end
                        2'b01: begin
                            be_d    = addr[1] ? 4'b1100 : 4'b0011;
                            wdata_d = {2{store_data[15:0]}};
                        end
                        default: begin
                            be_d    = 4'b1111;
                            wdata_d = store_data;
                        end
                    endcase
                    if (!legal) begin
                        state_d = DONE;
                        fault_d = 1'b1;
                    end else begin
                        state_d = mem_write ? WRITE : READ;
                    end
                end
            end
            READ, WRITE: begin
                if (bus_ack) begin
                    state_d = DONE;
                    if (state_q == READ) begin
                        load_data_d = load_ext;
                    end
                end else if (tmo_hit) begin
                    state_d = DONE;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q     <= IDLE;
            addr_q      <= 32'h0;
            funct3_q    <= 3'h0;
            be_q        <= 4'h0;
            wdata_q     <= 32'h0;
            load_data_q <= 32'h0;
            fault_q     <= 1'b0;
            cnt_q       <= 32'h0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            funct3_q    <= funct3_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            load_data_q <= load_data_d;
            fault_q     <= fault_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus_addr  = {addr_q[31:2], 2'b00};
    assign bus_wdata = wdata_q;
    assign bus_be    = be_q;
    assign bus_ren   = (state_q == READ);
    assign bus_wen   = (state_q == WRITE);
    assign load_data = load_data_q;
    assign fault     = fault_q;
    // Request-cycle stall is combinational so the PC never advances past a load/store;
    // gated by nRst so it drops immediately in reset even while a request is held.
    assign stall     = nRst & (((state_q == IDLE) & req) | (state_q == READ) | (state_q == WRITE));

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Purpose : scoreboard bench for data_mem_ctrl; driver queues expected completions, monitor checks each DONE.
// Latency : monitor samples on the falling edge; driver acts 1 time unit after the rising edge.
// Backpress: driver releases the request once stall drops (DONE) and bounds every wait with a cycle budget.
module tb_data_mem_ctrl;

    logic        clk;
    logic        nRst;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data, bus_rdata;
    logic        bus_ack;
    logic [31:0] bus_addr, bus_wdata, load_data;
    logic [3:0]  bus_be;
    logic        bus_ren, bus_wen, stall, fault;

    data_mem_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .nRst(nRst), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .store_data(store_data),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_ren(bus_ren), .bus_wen(bus_wen), .load_data(load_data),
        .stall(stall), .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        bus;
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        cw;
        logic        fault;
        logic [31:0] ld;
        int          stall_c;
        int          req_c;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    logic mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    function automatic exp_t mk(input logic b, input logic r, input logic w, input logic [31:0] a,
                                input logic [3:0] be, input logic [31:0] wd, input logic cw,
                                input logic f, input logic [31:0] ld, input int sc, input int rc);
        exp_t e;
        e.bus = b; e.ren = r; e.wen = w; e.addr = a; e.be = be; e.wdata = wd; e.cw = cw;
        e.fault = f; e.ld = ld; e.stall_c = sc; e.req_c = rc;
        return e;
    endfunction

    // Monitor: accumulates stall/request cycles and first-request bus fields, checks at DONE.
    initial begin
        logic        prev_stall;
        logic        bus_seen;
        logic        s_ren, s_wen;
        logic [31:0] s_addr, s_wdata;
        logic [3:0]  s_be;
        int          stall_cnt, req_cnt;
        logic        done_now;
        exp_t        e;
        prev_stall = 0; bus_seen = 0; stall_cnt = 0; req_cnt = 0;
        s_ren = 0; s_wen = 0; s_addr = 0; s_wdata = 0; s_be = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev_stall = 0; bus_seen = 0; stall_cnt = 0; req_cnt = 0;
            end else begin
                if (stall) stall_cnt++;
                if (bus_ren || bus_wen) begin
                    if (!bus_seen) begin
                        s_ren = bus_ren; s_wen = bus_wen; s_addr = bus_addr;
                        s_be = bus_be; s_wdata = bus_wdata;
                    end
                    bus_seen = 1;
                    req_cnt++;
                end
                done_now = prev_stall && !stall;
                if (!done_now) chk("stray_fault", {31'h0, fault}, 32'h0);
                if (done_now) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 32'h1, 32'h0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("fault", {31'h0, fault}, {31'h0, e.fault});
                        chk("load_data", load_data, e.ld);
                        chk("stall_cycles", stall_cnt, e.stall_c);
                        chk("req_cycles", req_cnt, e.req_c);
                        chk("bus_issued", {31'h0, bus_seen}, {31'h0, e.bus});
                        if (e.bus && bus_seen) begin
                            chk("bus_ren", {31'h0, s_ren}, {31'h0, e.ren});
                            chk("bus_wen", {31'h0, s_wen}, {31'h0, e.wen});
                            chk("bus_addr", s_addr, e.addr);
                            chk("bus_be", {28'h0, s_be}, {28'h0, e.be});
                            if (e.cw) chk("bus_wdata", s_wdata, e.wdata);
                        end
                    end
                    bus_seen = 0; stall_cnt = 0; req_cnt = 0;
                end
                prev_stall = stall;
            end
        end
    end

    // Driver: issue one request, ack in wait cycle k (0 = never), release once DONE is reached.
    task automatic txn(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input int k, input logic [31:0] rdat, input exp_t e);
        logic fin;
        exp_q.push_back(e);
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd; bus_rdata = rdat;
        fin = 0;
        for (int n = 1; n <= 40; n++) begin
            if (!fin) begin
                @(posedge clk); #1;
                if (!stall) begin
                    mem_read = 0; mem_write = 0; bus_ack = 0; fin = 1;
                end else begin
                    bus_ack = (k != 0) && (n == k);
                end
            end
        end
        chk("txn_completed", {31'h0, fin}, 32'h1);
        mem_read = 0; mem_write = 0; bus_ack = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        mem_read = 0; mem_write = 0; funct3 = 0; addr = 0; store_data = 0;
        bus_rdata = 0; bus_ack = 0;
        nRst = 1'b1;
        #1 nRst = 1'b0;
        #2;
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_ren", {31'h0, bus_ren}, 32'h0);
        chk("rst_wen", {31'h0, bus_wen}, 32'h0);
        chk("rst_fault", {31'h0, fault}, 32'h0);
        chk("rst_load_data", load_data, 32'h0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_be", {28'h0, bus_be}, 32'h0);
        repeat (3) @(posedge clk);
        #1 nRst = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Loads
        txn(1, 0, 3'b010, 32'h104, 32'h0, 3, 32'hDEADBEEF,
            mk(1, 1, 0, 32'h104, 4'b1111, 0, 0, 0, 32'hDEADBEEF, 4, 3));
        txn(1, 0, 3'b000, 32'h3, 32'h0, 1, 32'h80FF7F01,
            mk(1, 1, 0, 32'h0, 4'b1000, 0, 0, 0, 32'hFFFFFF80, 2, 1));
        txn(1, 0, 3'b100, 32'h3, 32'h0, 2, 32'h80FF7F01,
            mk(1, 1, 0, 32'h0, 4'b1000, 0, 0, 0, 32'h00000080, 3, 2));
        txn(1, 0, 3'b001, 32'h2, 32'h0, 1, 32'h80FF7F01,
            mk(1, 1, 0, 32'h0, 4'b1100, 0, 0, 0, 32'hFFFF80FF, 2, 1));
        txn(1, 0, 3'b000, 32'h1, 32'h0, 1, 32'h80FF7F01,
            mk(1, 1, 0, 32'h0, 4'b0010, 0, 0, 0, 32'h0000007F, 2, 1));
        txn(1, 0, 3'b101, 32'h0, 32'h0, 1, 32'h80FF7F01,
            mk(1, 1, 0, 32'h0, 4'b0011, 0, 0, 0, 32'h00007F01, 2, 1));

        // Stores: load_data must hold the last load result
        txn(0, 1, 3'b000, 32'h22, 32'h123456AB, 1, 32'hFFFFFFFF,
            mk(1, 0, 1, 32'h20, 4'b0100, 32'hABABABAB, 1, 0, 32'h00007F01, 2, 1));
        txn(0, 1, 3'b001, 32'h22, 32'h123456AB, 2, 32'hFFFFFFFF,
            mk(1, 0, 1, 32'h20, 4'b1100, 32'h56AB56AB, 1, 0, 32'h00007F01, 3, 2));
        txn(0, 1, 3'b010, 32'h8, 32'h55AA1234, 1, 32'hFFFFFFFF,
            mk(1, 0, 1, 32'h8, 4'b1111, 32'h55AA1234, 1, 0, 32'h00007F01, 2, 1));

        // Illegal accesses: one stall cycle, no bus, fault in DONE
        txn(0, 1, 3'b010, 32'h6, 32'h11111111, 1, 32'h0,
            mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h00007F01, 1, 0));
        txn(1, 0, 3'b011, 32'h0, 32'h0, 1, 32'h0,
            mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h00007F01, 1, 0));
        txn(1, 0, 3'b001, 32'h1, 32'h0, 1, 32'h0,
            mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h00007F01, 1, 0));

        // Timeout with no ack, then ack exactly on the abort cycle
        txn(1, 0, 3'b010, 32'h10, 32'h0, 0, 32'h99999999,
            mk(1, 1, 0, 32'h10, 4'b1111, 0, 0, 1, 32'h00007F01, 5, 4));
        txn(1, 0, 3'b010, 32'h14, 32'h0, 4, 32'hCAFEF00D,
            mk(1, 1, 0, 32'h14, 4'b1111, 0, 0, 0, 32'hCAFEF00D, 5, 4));

        // Reset in the middle of a READ
        mon_en = 1'b0;
        mem_read = 1; funct3 = 3'b010; addr = 32'h30;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_ren", {31'h0, bus_ren}, 32'h1);
        #2 nRst = 1'b0;
        #1;
        chk("async_rst_ren", {31'h0, bus_ren}, 32'h0);
        chk("async_rst_stall", {31'h0, stall}, 32'h0);
        chk("async_rst_load_data", load_data, 32'h0);
        chk("async_rst_fault", {31'h0, fault}, 32'h0);
        mem_read = 0;
        @(posedge clk); #1;
        nRst = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Simultaneous read and write: write wins
        txn(1, 1, 3'b010, 32'h40, 32'h11223344, 1, 32'h77777777,
            mk(1, 0, 1, 32'h40, 4'b1111, 32'h11223344, 1, 0, 32'h0, 2, 1));

        chk("scoreboard_empty", exp_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
